memory_unit: RTL and testbench

MEMORY_UNIT -- requirements
Module: memory_unit

---
 rtl/memory_unit_pkg.sv | 25 ++
 rtl/memory_unit_if.sv | 36 +++
 rtl/memory_unit_cpu_ram.sv | 27 ++
 rtl/memory_unit.sv | 119 +++++++++++
 tb/tb_memory_unit.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/memory_unit_pkg.sv
// rtl/memory_unit_pkg.sv - shared widths, loader states and bus-select codes
package memory_unit_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;

  // Loader FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } load_state_e;

  // Bus mux select codes; memory_unit drives mem_out when BUS_MEMORY is selected
  typedef enum logic [2:0] {
    BUS_NONE   = 3'd0,
    BUS_PC     = 3'd1,
    BUS_REG_A  = 3'd2,
    BUS_ALU    = 3'd3,
    BUS_REG_B  = 3'd4,
    BUS_MEMORY = 3'd5,
    BUS_IR     = 3'd6
  } bus_sel_e;

endpackage

// File: rtl/memory_unit_if.sv
// rtl/memory_unit_if.sv - CPU bus and program-loader signals of the memory unit
interface memory_unit_if
  import memory_unit_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  logic [DATA_W-1:0] bus_in;
  logic              memory_in;
  logic              ram_in;
  logic [DATA_W-1:0] mem_out;
  logic [ADDR_W-1:0] mar_q;

  logic              prog_mode;
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_last;
  logic              load_ready;
  logic              load_done;
  logic [ADDR_W:0]   load_count;
  logic              cpu_hold;

  // Control unit / loader side
  modport master (
    output bus_in, memory_in, ram_in, prog_mode, load_valid, load_data, load_last,
    input  mem_out, mar_q, load_ready, load_done, load_count, cpu_hold
  );

  // Memory unit side
  modport slave (
    input  bus_in, memory_in, ram_in, prog_mode, load_valid, load_data, load_last,
    output mem_out, mar_q, load_ready, load_done, load_count, cpu_hold
  );

endinterface

// File: rtl/memory_unit_cpu_ram.sv
// rtl/memory_unit_cpu_ram.sv - RAM with one write port and one asynchronous read port
module cpu_ram
  import memory_unit_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [1 << ADDR_W];

  // Contents are never reset so a loaded program survives a CPU reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/memory_unit.sv
// rtl/memory_unit.sv - MAR, program loader FSM and RAM write-address mux
module memory_unit
  import memory_unit_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input logic          clock,
  input logic          bReset_n,
  memory_unit_if.slave mem_if
);

  localparam int              DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W:0] COUNT_MAX = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PTR_TOP = '1;

  load_state_e       state_q, state_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [ADDR_W-1:0] load_ptr_q, load_ptr_d;
  logic [ADDR_W:0]   load_count_q, load_count_d;
  logic              run_q, run_d;

  logic              accept;
  logic              cpu_we;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;

  // Next-state logic; run_q is low for the edge at which reset is released, so that edge changes nothing
  always_comb begin
    state_d      = state_q;
    mar_d        = mar_q;
    load_ptr_d   = load_ptr_q;
    load_count_d = load_count_q;
    run_d        = 1'b1;
    accept       = 1'b0;
    cpu_we       = 1'b0;
    if (run_q) begin
      case (state_q)
        ST_IDLE: begin
          if (mem_if.memory_in) begin
            mar_d = mem_if.bus_in[ADDR_W-1:0];
          end
          cpu_we = mem_if.ram_in;
          if (mem_if.prog_mode) begin
            state_d      = ST_LOAD;
            load_ptr_d   = '0;
            load_count_d = '0;
          end
        end
        ST_LOAD: begin
          if (!mem_if.prog_mode) begin
            state_d = ST_IDLE;
            mar_d   = '0;
          end else if (mem_if.load_valid) begin
            accept     = 1'b1;
            load_ptr_d = load_ptr_q + 1'b1;
            if (load_count_q != COUNT_MAX) begin
              load_count_d = load_count_q + 1'b1;
            end
            if (mem_if.load_last || load_ptr_q == PTR_TOP) begin
              state_d = ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (!mem_if.prog_mode) begin
            state_d = ST_IDLE;
            mar_d   = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State registers with asynchronous clear; RAM is deliberately excluded
  always_ff @(posedge clock or negedge bReset_n) begin
    if (!bReset_n) begin
      state_q      <= ST_IDLE;
      mar_q        <= '0;
      load_ptr_q   <= '0;
      load_count_q <= '0;
      run_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      mar_q        <= mar_d;
      load_ptr_q   <= load_ptr_d;
      load_count_q <= load_count_d;
      run_q        <= run_d;
    end
  end

  // The loader owns the write port while loading; otherwise the CPU writes through MAR
  always_comb begin
    ram_we    = accept | cpu_we;
    ram_waddr = (state_q == ST_LOAD) ? load_ptr_q : mar_q;
    ram_wdata = (state_q == ST_LOAD) ? mem_if.load_data : mem_if.bus_in;
  end

  cpu_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (clock),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (mar_q),
    .rdata (mem_if.mem_out)
  );

  assign mem_if.mar_q      = mar_q;
  assign mem_if.load_ready = (state_q == ST_LOAD);
  assign mem_if.load_done  = (state_q == ST_DONE);
  assign mem_if.load_count = load_count_q;
  assign mem_if.cpu_hold   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_memory_unit.sv
// tb/tb_memory_unit.sv - directed self-checking bench for memory_unit
module tb_memory_unit;

  logic clock    = 1'b0;
  logic bReset_n = 1'b0;

  always #5 clock = ~clock;

  memory_unit_if ifc ();

  memory_unit dut (
    .clock    (clock),
    .bReset_n (bReset_n),
    .mem_if   (ifc)
  );

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  typedef enum int {M_IDLE, M_LOAD, M_DONE} mode_t;
  mode_t      m_mode;
  logic [7:0] m_ram [16];
  int         m_mar;
  int         m_ptr;
  int         m_cnt;
  bit         m_skip;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic model_reset();
    m_mode = M_IDLE;
    m_mar  = 0;
    m_ptr  = 0;
    m_cnt  = 0;
  endtask

  // Behaviour at one rising edge, from the inputs that were presented before it
  task automatic model_step();
    if (m_skip) begin
      m_skip = 1'b0;
    end else begin
      case (m_mode)
        M_IDLE: begin
          if (ifc.ram_in) m_ram[m_mar] = ifc.bus_in;
          if (ifc.memory_in) m_mar = int'(ifc.bus_in) % 16;
          if (ifc.prog_mode) begin
            m_mode = M_LOAD;
            m_ptr  = 0;
            m_cnt  = 0;
          end
        end
        M_LOAD: begin
          if (!ifc.prog_mode) begin
            m_mode = M_IDLE;
            m_mar  = 0;
          end else if (ifc.load_valid) begin
            m_ram[m_ptr] = ifc.load_data;
            m_cnt = (m_cnt < 16) ? m_cnt + 1 : 16;
            if (ifc.load_last || m_ptr == 15) m_mode = M_DONE;
            m_ptr = (m_ptr + 1) % 16;
          end
        end
        default: begin
          if (!ifc.prog_mode) begin
            m_mode = M_IDLE;
            m_mar  = 0;
          end
        end
      endcase
    end
  endtask

  task automatic cyc(input logic mi, input logic ri, input logic [7:0] b,
                     input logic pm, input logic lv, input logic [7:0] ld, input logic ll);
    @(negedge clock);
    ifc.memory_in  = mi;
    ifc.ram_in     = ri;
    ifc.bus_in     = b;
    ifc.prog_mode  = pm;
    ifc.load_valid = lv;
    ifc.load_data  = ld;
    ifc.load_last  = ll;
    @(posedge clock);
    model_step();
  endtask

  task automatic release_reset();
    @(negedge clock);
    ifc.memory_in  = 1'b0;
    ifc.ram_in     = 1'b0;
    ifc.bus_in     = 8'h00;
    ifc.prog_mode  = 1'b0;
    ifc.load_valid = 1'b0;
    ifc.load_data  = 8'h00;
    ifc.load_last  = 1'b0;
    bReset_n = 1'b1;
    m_skip   = 1'b1;
    @(posedge clock);
    model_step();
  endtask

  task automatic rd(input int addr, input logic [7:0] exp);
    cyc(1'b1, 1'b0, 8'(addr), 1'b0, 1'b0, 8'h00, 1'b0);
    #2;
    check($sformatf("ram[%0d]", addr), ifc.mem_out, exp);
  endtask

  // Every cycle: all outputs against the model
  always begin
    @(posedge clock);
    #2;
    if (chk_en) begin
      check("mem_out", ifc.mem_out, m_ram[m_mar]);
      check("mar_q", ifc.mar_q, m_mar);
      check("load_ready", ifc.load_ready, m_mode == M_LOAD);
      check("load_done", ifc.load_done, m_mode == M_DONE);
      check("load_count", ifc.load_count, m_cnt);
      check("cpu_hold", ifc.cpu_hold, m_mode != M_IDLE);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    ifc.memory_in  = 1'b0;
    ifc.ram_in     = 1'b0;
    ifc.bus_in     = 8'h00;
    ifc.prog_mode  = 1'b0;
    ifc.load_valid = 1'b0;
    ifc.load_data  = 8'h00;
    ifc.load_last  = 1'b0;
    m_skip = 1'b0;
    model_reset();

    #12;
    check("rst mar_q", ifc.mar_q, 0);
    check("rst load_ready", ifc.load_ready, 0);
    check("rst load_done", ifc.load_done, 0);
    check("rst cpu_hold", ifc.cpu_hold, 0);
    check("rst load_count", ifc.load_count, 0);
    release_reset();

    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 1'b0, 8'(i), 1'b0, 1'b0, 8'h00, 1'b0);
      cyc(1'b0, 1'b1, 8'(8'h80 + i), 1'b0, 1'b0, 8'h00, 1'b0);
    end
    chk_en = 1'b1;

    // CPU write then read back through MAR
    cyc(1'b1, 1'b0, 8'h0E, 1'b0, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 1'b1, 8'h2A, 1'b0, 1'b0, 8'h00, 1'b0);
    cyc(1'b1, 1'b0, 8'h0E, 1'b0, 1'b0, 8'h00, 1'b0);
    #2;
    check("cpu rd mem_out", ifc.mem_out, 8'h2A);
    check("cpu rd mar_q", ifc.mar_q, 4'hE);
    // memory_in and ram_in together: write lands at old MAR
    cyc(1'b1, 1'b1, 8'h03, 1'b0, 1'b0, 8'h00, 1'b0);
    #2;
    check("both mar_q", ifc.mar_q, 4'h3);
    rd(14, 8'h03);

    // Full load with load_valid held one cycle past the top address
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 17; i++) cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'(8'h10 + i), 1'b0);
    #2;
    check("full load_done", ifc.load_done, 1);
    check("full load_count", ifc.load_count, 16);
    check("full load_ready", ifc.load_ready, 0);
    check("full cpu_hold", ifc.cpu_hold, 1);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    #2;
    check("full exit mar_q", ifc.mar_q, 0);
    for (int i = 0; i < 16; i++) rd(i, 8'(8'h10 + i));

    // Short load terminated by load_last
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'hA0, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'hA1, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'hA2, 1'b1);
    #2;
    check("short load_done", ifc.load_done, 1);
    check("short load_count", ifc.load_count, 3);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    #2;
    check("short cpu_hold", ifc.cpu_hold, 0);
    check("short mar_q", ifc.mar_q, 0);
    rd(0, 8'hA0);
    rd(2, 8'hA2);
    rd(3, 8'h13);
    rd(15, 8'h1F);

    // CPU strobes are locked out while loading
    cyc(1'b1, 1'b0, 8'h07, 1'b0, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
    cyc(1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b0);
    #2;
    check("lockout mar_q", ifc.mar_q, 7);
    check("lockout mem_out", ifc.mem_out, 8'h17);
    check("lockout load_ready", ifc.load_ready, 1);

    // Abort after five accepted bytes
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'(8'h50 + i), 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h99, 1'b0);
    #2;
    check("abort load_done", ifc.load_done, 0);
    check("abort load_count", ifc.load_count, 5);
    check("abort cpu_hold", ifc.cpu_hold, 0);
    check("abort mar_q", ifc.mar_q, 0);
    for (int i = 0; i < 5; i++) rd(i, 8'(8'h50 + i));
    rd(5, 8'h15);
    rd(7, 8'h17);

    // Asynchronous reset between clock edges during a load
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h60, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h61, 1'b0);
    #3;
    bReset_n = 1'b0;
    model_reset();
    #1;
    check("areset load_ready", ifc.load_ready, 0);
    check("areset cpu_hold", ifc.cpu_hold, 0);
    check("areset load_count", ifc.load_count, 0);
    check("areset mar_q", ifc.mar_q, 0);
    check("areset load_done", ifc.load_done, 0);
    release_reset();
    rd(0, 8'h60);
    rd(1, 8'h61);
    rd(2, 8'h52);
    rd(15, 8'h1F);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
